// File: rtl/shift_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : shift_pkg
//  Description : Shared shift/rotate mode encodings. The ALU decoder and the
//                rotate/shift pipeline both use these values, so the encoding
//                lives in exactly one place.
//  Contents    : shift_mode_e -- SLL, SRL, SRA, ROR (2-bit)
//  Revision    : 1.0  initial release
// ============================================================================
package shift_pkg;

  typedef enum logic [1:0] {
    MODE_SLL = 2'b00,   // logical left, zero fill
    MODE_SRL = 2'b01,   // logical right, zero fill
    MODE_SRA = 2'b10,   // arithmetic right, sign fill
    MODE_ROR = 2'b11    // rotate right
  } shift_mode_e;

endpackage : shift_pkg
`default_nettype wire

// File: rtl/shift_level.sv
`default_nettype none
// ============================================================================
//  Module      : shift_level
//  Description : One combinational level of a logarithmic shifter. Shifts or
//                rotates the operand right/left by the fixed distance SHIFT
//                when en_i is set, otherwise passes it through unchanged.
//  Ports       : data_i  [WIDTH]  partial result entering this level
//                mode_i  [2]      shift_mode_e encoding
//                en_i    [1]      amount bit for this level
//                data_o  [WIDTH]  partial result leaving this level
//  Revision    : 1.0  initial release
// ============================================================================
module shift_level
  import shift_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SHIFT = 1
) (
  input  logic [WIDTH-1:0] data_i,
  input  logic [1:0]       mode_i,
  input  logic             en_i,
  output logic [WIDTH-1:0] data_o
);

  always_comb begin
    data_o = data_i;
    if (en_i) begin
      case (mode_i)
        MODE_SLL: data_o = data_i << SHIFT;
        MODE_SRL: data_o = data_i >> SHIFT;
        // The MSB is preserved by every earlier SRA level, so the current
        // partial MSB is still the original operand sign.
        MODE_SRA: data_o = $signed(data_i) >>> SHIFT;
        default:  data_o = {data_i[SHIFT-1:0], data_i[WIDTH-1:SHIFT]};
      endcase
    end
  end

endmodule : shift_level
`default_nettype wire

// File: rtl/rotate_shift_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : rotate_shift_pipe
//  Description : Pipelined barrel shifter/rotator. log2(WIDTH) shift levels
//                are spread evenly over STAGES register stages; the whole
//                pipeline advances as one unit under valid/ready flow control.
//  Ports       : clk, rst_n (async, active-low)
//                in_valid/in_ready, in_data[WIDTH], in_amt[WIDTH], in_mode[2]
//                flush     -- drops every in-flight operation
//                out_valid/out_ready, out_data[WIDTH], out_zero, out_neg
//  Revision    : 1.0  initial release
// ============================================================================
module rotate_shift_pipe
  import shift_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int STAGES = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [WIDTH-1:0] in_amt,
  input  logic [1:0]       in_mode,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_zero,
  output logic             out_neg
);

  localparam int LOG  = $clog2(WIDTH);
  localparam int LPS  = LOG / STAGES;   // shift levels per register stage
  localparam int LAST = STAGES - 1;

  logic             out_valid_q;
  logic [WIDTH-1:0] out_data_q;
  logic             out_zero_q;
  logic             out_neg_q;

  logic w_advance;
  logic w_ovr_in;

  // Stage inputs (index s = what stage s works on) and stage results.
  logic             w_stg_valid [STAGES];
  logic [1:0]       w_stg_mode  [STAGES];
  logic [LOG-1:0]   w_stg_amt   [STAGES];
  logic             w_stg_ovr   [STAGES];
  logic [WIDTH-1:0] w_stg_data  [STAGES];
  logic [WIDTH-1:0] w_stg_res   [STAGES];

  assign w_advance = !out_valid_q || out_ready;
  assign in_ready  = w_advance && !flush;

  // Amount bits above the level range only matter for shifts; a rotate uses
  // the amount modulo WIDTH, which is exactly the low LOG bits.
  assign w_ovr_in = (in_mode != MODE_ROR) && (|in_amt[WIDTH-1:LOG]);

  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    if (s == 0) begin : g_first
      assign w_stg_valid[s] = in_valid && !flush;
      assign w_stg_mode[s]  = in_mode;
      assign w_stg_amt[s]   = in_amt[LOG-1:0];
      assign w_stg_ovr[s]   = w_ovr_in;
      assign w_stg_data[s]  = in_data;
    end else begin : g_reg
      logic             valid_q;
      logic [1:0]       mode_q;
      logic [LOG-1:0]   amt_q;
      logic             ovr_q;
      logic [WIDTH-1:0] data_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          valid_q <= 1'b0;
        end else if (flush) begin
          valid_q <= 1'b0;
        end else if (w_advance) begin
          valid_q <= w_stg_valid[s-1];
        end
      end

      // Payload is qualified by valid_q, so it carries no reset.
      always_ff @(posedge clk) begin
        if (w_advance) begin
          mode_q <= w_stg_mode[s-1];
          amt_q  <= w_stg_amt[s-1];
          ovr_q  <= w_stg_ovr[s-1];
          data_q <= w_stg_res[s-1];
        end
      end

      assign w_stg_valid[s] = valid_q;
      assign w_stg_mode[s]  = mode_q;
      assign w_stg_amt[s]   = amt_q;
      assign w_stg_ovr[s]   = ovr_q;
      assign w_stg_data[s]  = data_q;
    end

    logic [WIDTH-1:0] w_chain [LPS+1];
    assign w_chain[0] = w_stg_data[s];

    for (genvar j = 0; j < LPS; j++) begin : g_level
      shift_level #(
        .WIDTH (WIDTH),
        .SHIFT (1 << (s*LPS + j))
      ) u_level (
        .data_i (w_chain[j]),
        .mode_i (w_stg_mode[s]),
        .en_i   (w_stg_amt[s][s*LPS + j]),
        .data_o (w_chain[j+1])
      );
    end

    assign w_stg_res[s] = w_chain[LPS];
  end

  // Over-range shifts saturate to the fill value. For SRA the chain has kept
  // the operand sign in its MSB, so that bit is the fill.
  logic [WIDTH-1:0] w_fill;
  logic [WIDTH-1:0] out_data_d;

  assign w_fill     = (w_stg_mode[LAST] == MODE_SRA) ?
                      {WIDTH{w_stg_res[LAST][WIDTH-1]}} : '0;
  assign out_data_d = w_stg_ovr[LAST] ? w_fill : w_stg_res[LAST];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_zero_q  <= 1'b1;
      out_neg_q   <= 1'b0;
    end else begin
      if (flush) begin
        out_valid_q <= 1'b0;
      end else if (w_advance) begin
        out_valid_q <= w_stg_valid[LAST];
      end
      if (w_advance) begin
        out_data_q <= out_data_d;
        out_zero_q <= (out_data_d == '0);
        out_neg_q  <= out_data_d[WIDTH-1];
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_zero  = out_zero_q;
  assign out_neg   = out_neg_q;

endmodule : rotate_shift_pipe
`default_nettype wire

// File: doc/rotate_shift_pipe.md
ROTATE_SHIFT_PIPE -- requirements
Module: rotate_shift_pipe

Interface
REQ-001 Parameter: WIDTH, default 16, data width; SHALL be a power of two, 8..64.
REQ-002 Parameter: STAGES, default log2(WIDTH), number of register stages; SHALL divide log2(WIDTH) evenly.
REQ-003 Port: clk  input  1  rising-edge clock.
REQ-004 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-005 Port: in_valid  input  1  operation presented.
REQ-006 Port: in_ready  output  1  operation accepted this cycle when high with in_valid.
REQ-007 Port: in_data  input  WIDTH  operand.
REQ-008 Port: in_amt  input  WIDTH  shift/rotate amount, full-width unsigned.
REQ-009 Port: in_mode  input  2  00 SLL, 01 SRL, 10 SRA, 11 ROR.
REQ-010 Port: flush  input  1  discard all in-flight operations.
REQ-011 Port: out_valid  output  1  result available.
REQ-012 Port: out_ready  input  1  consumer accepts result.
REQ-013 Port: out_data  output  WIDTH  result.
REQ-014 Port: out_zero  output  1  out_data is all zeros.
REQ-015 Port: out_neg  output  1  out_data MSB.

Function
REQ-016 Result SHALL be computed as a logarithmic shifter of log2(WIDTH) levels; level k shifts by 2^k when effective-amount bit k is set.
REQ-017 ROR effective amount SHALL be in_amt mod WIDTH (amount WIDTH gives in_data unchanged, WIDTH+1 equals 1).
REQ-018 SLL/SRL with in_amt >= WIDTH SHALL give zero; SRA with in_amt >= WIDTH SHALL give WIDTH copies of in_data MSB.
REQ-019 SRA SHALL fill vacated bits with in_data MSB; SLL/SRL fill with zero.
REQ-020 Levels SHALL be distributed evenly over STAGES registers; latency from accept to out_valid SHALL be exactly STAGES cycles with no stall.
REQ-021 Each stage SHALL carry valid, mode, partial data, remaining amount bits and the over-range flag.
REQ-022 Pipeline SHALL advance as a unit: advance = !out_valid || out_ready; in_ready = advance.
REQ-023 When advance is low all stage registers including out_* SHALL hold; out_data SHALL remain stable while out_valid && !out_ready.
REQ-024 Throughput SHALL be one operation per cycle when out_ready stays high; empty stages (bubbles) propagate with valid low.
REQ-025 flush SHALL clear every stage valid bit on the next edge, including out_valid, regardless of out_ready; in_ready SHALL be low while flush is high; no operation is accepted that cycle.
REQ-026 out_zero and out_neg SHALL be registered with out_data in the final stage.
REQ-027 Simultaneous accept and output handshake SHALL both complete in the same cycle without loss or duplication.

Reset
REQ-028 On rst_n low, asynchronously: all stage valid bits and out_valid SHALL be 0; out_data 0; out_zero 1; out_neg 0.
REQ-029 Reset asserted mid-operation SHALL drop all in-flight operations; first acceptance possible in the first cycle after rst_n rises.
REQ-030 Data-path registers other than out_* need not be reset provided valid bits are.

Structure
REQ-031 Mode encodings (SLL, SRL, SRA, ROR) SHALL be constants in shared package shift_pkg, reused by ALU decode.
REQ-032 One sub-module shift_level SHALL implement a single combinational level (parameters WIDTH, SHIFT), instantiated log2(WIDTH) times by generate.
REQ-033 Stage registers, handshake and flush logic SHALL live in rotate_shift_pipe.

Verification (WIDTH=16, STAGES=4 unless noted)
REQ-034 ROR in_data 16'h8001, in_amt 1 -> out_data 16'hC000, out_neg 1, exactly 4 cycles after accept; in_amt 16 -> 16'h8001; in_amt 17 -> 16'hC000.
REQ-035 SRA 16'h8000 amt 15 -> 16'hFFFF; amt 40 -> 16'hFFFF; SRL 16'h8000 amt 16 -> 16'h0000, out_zero 1; SLL 16'h0001 amt 15 -> 16'h8000.
REQ-036 Back-to-back 8 ops, out_ready held low 3 cycles mid-stream -> out_data frozen during stall, in_ready low, all 8 results in order, none lost or duplicated.
REQ-037 flush asserted with 3 ops in flight and out_valid high -> out_valid 0 next cycle, no flushed result appears afterwards, next op accepted returns correct result.
REQ-038 rst_n pulsed low asynchronously between clock edges with ops in flight -> out_valid 0, out_zero 1 immediately; no stale result after release.
REQ-039 Randomised 10k ops per mode, WIDTH 8/16/32, STAGES 1 and log2(WIDTH), random out_ready -> matches reference model.
